int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl_pkg.sv | 42 ++++
 rtl/int_ctrl_irq_edge_latch.sv | 50 +++++
 rtl/int_ctrl.sv | 132 +++++++++++++
 tb/tb_int_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// int_ctrl_pkg
// Shared definitions for the interrupt controller: source count, default
// handler vectors, the FSM state encoding, and small helpers for source
// selection and one-hot conversion.
// -----------------------------------------------------------------------------
package int_ctrl_pkg;

  localparam int NUM_IRQ = 3;

  localparam logic [31:0] DEF_VEC0 = 32'h0000_3000;
  localparam logic [31:0] DEF_VEC1 = 32'h0000_3100;
  localparam logic [31:0] DEF_VEC2 = 32'h0000_3200;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Fixed priority: source 2 wins, source 0 loses. Caller guarantees at
  // least one eligible bit when the result is used.
  function automatic logic [1:0] pick_src(input logic [NUM_IRQ-1:0] elig);
    logic [1:0] s;
    s = 2'd0;
    if (elig[2])      s = 2'd2;
    else if (elig[1]) s = 2'd1;
    return s;
  endfunction

  function automatic logic [NUM_IRQ-1:0] src_onehot(input logic [1:0] s);
    logic [NUM_IRQ-1:0] oh;
    case (s)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/int_ctrl_irq_edge_latch.sv
// -----------------------------------------------------------------------------
// irq_edge_latch
// Samples the raw request lines every cycle and latches a pending bit on each
// 0->1 transition. A pending bit stays set until explicitly cleared; a new
// rising edge arriving in the same cycle as its clear keeps the bit set.
//
// Ports
//   clk        : clock, rising edge
//   clr        : synchronous active-high reset (sample reg and pending -> 0)
//   irq_i      : raw request lines
//   clear_i    : one-hot clear of pending bits (from the take logic)
//   pending_o  : latched, not-yet-taken requests
// -----------------------------------------------------------------------------
module irq_edge_latch
  import int_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] clear_i,
  output logic [NUM_IRQ-1:0] pending_o
);

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] pending_d;
  logic [NUM_IRQ-1:0] rise;

  // Because irq_q resets to 0, a line held high through reset shows up as
  // one rising edge right after reset releases.
  assign rise = irq_i & ~irq_q;

  // Clear first, then OR in new edges so a coinciding edge wins.
  assign pending_d = (pending_q & ~clear_i) | rise;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      irq_q     <= '0;
      pending_q <= '0;
    end else begin
      irq_q     <= irq_i;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl
// Three-source, non-nesting interrupt controller. Rising edges on irq_in are
// latched as pending; the highest-priority unmasked pending source is taken
// when globally enabled and the pipeline is not stalled. Taking an interrupt
// spends one SAVE cycle (EPC write + PC redirect), then stays in SERVICE until
// ERET.
//
// Ports
//   clk        : clock, rising edge
//   clr        : synchronous active-high reset
//   irq_in     : raw interrupt request lines (rising-edge significant)
//   mask_in    : per-source mask, 1 blocks the source
//   ie_in      : global interrupt enable
//   stall      : pipeline stalled, no take while high
//   pc_cur     : resume PC at the take point
//   eret       : ERET decoded this cycle
//   EPC_WE     : EPC write strobe (SAVE only)
//   EPC_in     : value written to EPC, holds last captured PC
//   int_take   : PC redirect to int_vector (SAVE only)
//   int_vector : handler address, holds last value
//   in_service : handler executing
//   pending    : latched, not-yet-taken requests
// -----------------------------------------------------------------------------
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter logic [31:0] VEC0 = DEF_VEC0,
  parameter logic [31:0] VEC1 = DEF_VEC1,
  parameter logic [31:0] VEC2 = DEF_VEC2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [2:0]  irq_in,
  input  logic [2:0]  mask_in,
  input  logic        ie_in,
  input  logic        stall,
  input  logic [31:0] pc_cur,
  input  logic        eret,
  output logic        EPC_WE,
  output logic [31:0] EPC_in,
  output logic        int_take,
  output logic [31:0] int_vector,
  output logic        in_service,
  output logic [2:0]  pending
);

  state_t             state_q, state_d;
  logic [1:0]         src_q, src_d;
  logic [31:0]        epc_q, epc_d;
  logic [31:0]        vec_q, vec_d;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] clear_vec;
  logic [1:0]         sel;

  function automatic logic [31:0] vec_of(input logic [1:0] s);
    logic [31:0] v;
    case (s)
      2'd1:    v = VEC1;
      2'd2:    v = VEC2;
      default: v = VEC0;
    endcase
    return v;
  endfunction

  irq_edge_latch u_latch (
    .clk       (clk),
    .clr       (clr),
    .irq_i     (irq_in),
    .clear_i   (clear_vec),
    .pending_o (pend)
  );

  assign eligible = pend & ~mask_in;
  assign sel      = pick_src(eligible);

  // NOTE: every signal driven here gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    epc_d     = epc_q;
    vec_d     = vec_q;
    clear_vec = '0;
    case (state_q)
      IDLE: begin
        // PC and vector are captured on entry to SAVE so they are stable for
        // the whole SAVE cycle and hold afterwards.
        if ((|eligible) && ie_in && !stall) begin
          state_d = SAVE;
          src_d   = sel;
          epc_d   = pc_cur;
          vec_d   = vec_of(sel);
        end
      end
      SAVE: begin
        clear_vec = src_onehot(src_q);
        state_d   = SERVICE;
      end
      SERVICE: begin
        // No nesting: pending keeps latching, but nothing is taken here.
        if (eret) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      src_q   <= 2'd0;
      epc_q   <= 32'd0;
      vec_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      epc_q   <= epc_d;
      vec_q   <= vec_d;
    end
  end

  // Strobes decode straight from the state register, so a reset during SAVE
  // drops them in the very next cycle.
  assign EPC_WE     = (state_q == SAVE);
  assign int_take   = (state_q == SAVE);
  assign in_service = (state_q == SERVICE);
  assign EPC_in     = epc_q;
  assign int_vector = vec_q;
  assign pending    = pend;

endmodule

// File: tb/tb_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_ctrl
// Directed self-checking bench for int_ctrl. Inputs change and outputs are
// sampled 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_int_ctrl;

  logic        clk;
  logic        clr;
  logic [2:0]  irq_in;
  logic [2:0]  mask_in;
  logic        ie_in;
  logic        stall;
  logic [31:0] pc_cur;
  logic        eret;
  logic        EPC_WE;
  logic [31:0] EPC_in;
  logic        int_take;
  logic [31:0] int_vector;
  logic        in_service;
  logic [2:0]  pending;

  int total;
  int bad;

  int_ctrl dut (
    .clk        (clk),
    .clr        (clr),
    .irq_in     (irq_in),
    .mask_in    (mask_in),
    .ie_in      (ie_in),
    .stall      (stall),
    .pc_cur     (pc_cur),
    .eret       (eret),
    .EPC_WE     (EPC_WE),
    .EPC_in     (EPC_in),
    .int_take   (int_take),
    .int_vector (int_vector),
    .in_service (in_service),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Return to IDLE from SERVICE with a one-cycle eret.
  task automatic finish_service();
    eret = 1'b1;
    step();
    eret = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; irq_in = 3'b000; mask_in = 3'b000; ie_in = 1'b1;
    stall = 1'b0; pc_cur = 32'h0; eret = 1'b0;
    step(); step();
    total++; if (EPC_WE !== 1'b0) begin bad++; $display("FAIL reset_epc_we: got %b want 0", EPC_WE); end
    total++; if (int_take !== 1'b0) begin bad++; $display("FAIL reset_take: got %b want 0", int_take); end
    total++; if (in_service !== 1'b0) begin bad++; $display("FAIL reset_service: got %b want 0", in_service); end
    total++; if (pending !== 3'b000) begin bad++; $display("FAIL reset_pending: got %b want 000", pending); end
    total++; if (EPC_in !== 32'h0) begin bad++; $display("FAIL reset_epc_in: got %h want 0", EPC_in); end
    total++; if (int_vector !== 32'h0) begin bad++; $display("FAIL reset_vector: got %h want 0", int_vector); end
    clr = 1'b0;
    step();
  endtask

  task automatic test_basic();
    pc_cur = 32'h0000_0040;
    irq_in = 3'b010;
    step();
    total++; if (pending !== 3'b010) begin bad++; $display("FAIL basic_pending_set: got %b want 010", pending); end
    total++; if (EPC_WE !== 1'b0) begin bad++; $display("FAIL basic_no_early_we: got %b want 0", EPC_WE); end
    irq_in = 3'b000;
    step();
    total++; if (EPC_WE !== 1'b1) begin bad++; $display("FAIL basic_epc_we: got %b want 1", EPC_WE); end
    total++; if (int_take !== 1'b1) begin bad++; $display("FAIL basic_take: got %b want 1", int_take); end
    total++; if (EPC_in !== 32'h40) begin bad++; $display("FAIL basic_epc_in: got %h want 00000040", EPC_in); end
    total++; if (int_vector !== 32'h3100) begin bad++; $display("FAIL basic_vector: got %h want 00003100", int_vector); end
    // eret during SAVE must be ignored.
    eret = 1'b1;
    pc_cur = 32'h0000_0bad;
    step();
    eret = 1'b0;
    total++; if (EPC_WE !== 1'b0) begin bad++; $display("FAIL basic_we_one_cycle: got %b want 0", EPC_WE); end
    total++; if (in_service !== 1'b1) begin bad++; $display("FAIL basic_service: got %b want 1", in_service); end
    total++; if (pending !== 3'b000) begin bad++; $display("FAIL basic_pending_clr: got %b want 000", pending); end
    total++; if (EPC_in !== 32'h40) begin bad++; $display("FAIL basic_epc_hold: got %h want 00000040", EPC_in); end
    total++; if (int_vector !== 32'h3100) begin bad++; $display("FAIL basic_vec_hold: got %h want 00003100", int_vector); end
    finish_service();
    total++; if (in_service !== 1'b0) begin bad++; $display("FAIL basic_eret_idle: got %b want 0", in_service); end
  endtask

  task automatic test_priority();
    irq_in = 3'b101;
    step();
    irq_in = 3'b000;
    total++; if (pending !== 3'b101) begin bad++; $display("FAIL prio_pending: got %b want 101", pending); end
    step();
    total++; if (int_vector !== 32'h3200) begin bad++; $display("FAIL prio_first_vec: got %h want 00003200", int_vector); end
    step();
    total++; if (pending !== 3'b001) begin bad++; $display("FAIL prio_left_pending: got %b want 001", pending); end
    finish_service();
    total++; if (int_take !== 1'b0) begin bad++; $display("FAIL prio_idle_gap: got %b want 0", int_take); end
    step();
    total++; if (int_take !== 1'b1) begin bad++; $display("FAIL prio_second_take: got %b want 1", int_take); end
    total++; if (int_vector !== 32'h3000) begin bad++; $display("FAIL prio_second_vec: got %h want 00003000", int_vector); end
    step();
    total++; if (pending !== 3'b000) begin bad++; $display("FAIL prio_all_clear: got %b want 000", pending); end
    finish_service();
  endtask

  task automatic test_mask();
    mask_in = 3'b010;
    irq_in = 3'b010;
    step();
    irq_in = 3'b000;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (int_take !== 1'b0) begin bad++; $display("FAIL mask_blocks[%0d]: got %b want 0", i, int_take); end
    end
    total++; if (pending !== 3'b010) begin bad++; $display("FAIL mask_pending_kept: got %b want 010", pending); end
    mask_in = 3'b000;
    step();
    total++; if (int_take !== 1'b1) begin bad++; $display("FAIL mask_unmask_take: got %b want 1", int_take); end
    total++; if (int_vector !== 32'h3100) begin bad++; $display("FAIL mask_vec: got %h want 00003100", int_vector); end
    step();
    finish_service();
  endtask

  task automatic test_global_enable();
    ie_in = 1'b0;
    irq_in = 3'b001;
    step();
    irq_in = 3'b000;
    step(); step();
    total++; if (EPC_WE !== 1'b0) begin bad++; $display("FAIL ie_blocks: got %b want 0", EPC_WE); end
    ie_in = 1'b1;
    step();
    total++; if (int_vector !== 32'h3000) begin bad++; $display("FAIL ie_take_vec: got %h want 00003000", int_vector); end
    step();
    finish_service();
  endtask

  task automatic test_stall();
    stall = 1'b1;
    irq_in = 3'b100;
    pc_cur = 32'h0000_0070;
    step();
    irq_in = 3'b000;
    for (int i = 0; i < 3; i++) begin
      pc_cur = 32'h0000_0074 + 32'(i * 4);
      step();
      total++; if (EPC_WE !== 1'b0) begin bad++; $display("FAIL stall_no_we[%0d]: got %b want 0", i, EPC_WE); end
    end
    stall = 1'b0;
    pc_cur = 32'h0000_0088;
    step();
    pc_cur = 32'h0000_0099;
    total++; if (EPC_WE !== 1'b1) begin bad++; $display("FAIL stall_release_we: got %b want 1", EPC_WE); end
    total++; if (EPC_in !== 32'h88) begin bad++; $display("FAIL stall_epc_in: got %h want 00000088", EPC_in); end
    step();
    finish_service();
  endtask

  task automatic test_no_nesting();
    irq_in = 3'b001;
    step();
    irq_in = 3'b000;
    step(); step();
    irq_in = 3'b010;
    step();
    irq_in = 3'b000;
    total++; if (pending !== 3'b010) begin bad++; $display("FAIL nest_latched: got %b want 010", pending); end
    step();
    total++; if (int_take !== 1'b0) begin bad++; $display("FAIL nest_no_take: got %b want 0", int_take); end
    total++; if (in_service !== 1'b1) begin bad++; $display("FAIL nest_still_service: got %b want 1", in_service); end
    finish_service();
    step();
    total++; if (int_vector !== 32'h3100) begin bad++; $display("FAIL nest_after_eret_vec: got %h want 00003100", int_vector); end
    step();
    finish_service();
  endtask

  task automatic test_set_wins();
    irq_in = 3'b100;
    step();
    irq_in = 3'b000;
    step();
    total++; if (int_take !== 1'b1) begin bad++; $display("FAIL setwin_in_save: got %b want 1", int_take); end
    irq_in = 3'b100;
    step();
    irq_in = 3'b000;
    total++; if (pending !== 3'b100) begin bad++; $display("FAIL setwin_pending: got %b want 100", pending); end
    finish_service();
    step();
    total++; if (int_vector !== 32'h3200) begin bad++; $display("FAIL setwin_retake: got %h want 00003200", int_vector); end
    step();
    finish_service();
  endtask

  task automatic test_clr_abort();
    pc_cur = 32'h0000_0120;
    irq_in = 3'b010;
    step();
    irq_in = 3'b000;
    step();
    total++; if (EPC_WE !== 1'b1) begin bad++; $display("FAIL abort_in_save: got %b want 1", EPC_WE); end
    clr = 1'b1;
    irq_in = 3'b001;
    step();
    clr = 1'b0;
    total++; if (EPC_WE !== 1'b0) begin bad++; $display("FAIL abort_we: got %b want 0", EPC_WE); end
    total++; if (int_take !== 1'b0) begin bad++; $display("FAIL abort_take: got %b want 0", int_take); end
    total++; if (in_service !== 1'b0) begin bad++; $display("FAIL abort_service: got %b want 0", in_service); end
    total++; if (pending !== 3'b000) begin bad++; $display("FAIL abort_pending: got %b want 000", pending); end
    total++; if (EPC_in !== 32'h0) begin bad++; $display("FAIL abort_epc_in: got %h want 0", EPC_in); end
    total++; if (int_vector !== 32'h0) begin bad++; $display("FAIL abort_vector: got %h want 0", int_vector); end
    // irq_in[0] held high through reset: one edge after release. eret in
    // IDLE must not change anything.
    eret = 1'b1;
    step();
    eret = 1'b0;
    total++; if (pending !== 3'b001) begin bad++; $display("FAIL held_line_edge: got %b want 001", pending); end
    total++; if (in_service !== 1'b0 || int_take !== 1'b0) begin bad++; $display("FAIL eret_idle: got svc=%b take=%b want 0 0", in_service, int_take); end
    step();
    total++; if (int_vector !== 32'h3000) begin bad++; $display("FAIL held_take_vec: got %h want 00003000", int_vector); end
    step();
    total++; if (pending !== 3'b000) begin bad++; $display("FAIL held_no_reedge: got %b want 000", pending); end
    clr = 1'b1;
    step();
    clr = 1'b0;
    irq_in = 3'b000;
    total++; if (in_service !== 1'b0) begin bad++; $display("FAIL abort_service_state: got %b want 0", in_service); end
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_global_enable();
    test_stall();
    test_no_nesting();
    test_set_wins();
    test_clr_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
